// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler: turns four debounced push-buttons into Samsung-style IR command frames.
//
// Each active-low KEY bit passes a 2-flop synchronizer and a per-key debounce counter. A
// debounced press latches a pending request. A round-robin arbiter hands one request at a time
// to the protocol engine as a 32-bit frame word. After the engine reports completion, a mandatory
// idle gap is observed before the next grant.
//
// Optional feature: define IR_REPEAT_EN to enable the HOLD state. In that build a key that is
// still held after the gap re-issues its command every RPT_CYCLES.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   KEY[3:0]   raw push-buttons, active-low, asynchronous to clk
//   cmd_ready  protocol engine can accept a command this cycle
//   tx_done    one-cycle pulse: protocol engine finished the frame
//   command    frame word {ADDR, ADDR, data, ~data}, MSB first
//   cmd_valid  command valid, held until accepted
//   grant_id   index of the key owning the current/last command
//   busy       high whenever the scheduler is not idle
module ir_cmd_scheduler #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned GAP_CYCLES = 5000000,
    parameter int unsigned RPT_CYCLES = 5000000,
    parameter logic [7:0]  ADDR       = 8'h07,
    parameter logic [7:0]  CMD0       = 8'h02,
    parameter logic [7:0]  CMD1       = 8'h07,
    parameter logic [7:0]  CMD2       = 8'h0B,
    parameter logic [7:0]  CMD3       = 8'h0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  KEY,
    input  logic        cmd_ready,
    input  logic        tx_done,
    output logic [31:0] command,
    output logic        cmd_valid,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam int unsigned DW     = $clog2(DEB_CYCLES + 1);
    localparam int unsigned MaxCnt = (GAP_CYCLES > RPT_CYCLES) ? GAP_CYCLES : RPT_CYCLES;
    localparam int unsigned GW     = $clog2(MaxCnt + 1);

    localparam logic [DW-1:0] DebLast = DW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);
`ifdef IR_REPEAT_EN
    localparam logic [GW-1:0] RptLast = GW'(RPT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitDone,
`ifdef IR_REPEAT_EN
        StHold,
`endif
        StGap
    } state_e;

    state_e        r_state;
    state_e        w_state_d;

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_deb;
    logic [DW-1:0] r_deb_cnt [4];
    logic [3:0]    w_deb_flip;
    logic [3:0]    w_press;

    logic [3:0]    r_pending;
    logic [3:0]    w_pend_clr;
    logic [3:0]    w_rpt_set;
    logic [3:0]    w_grant_oh;

    logic [1:0]    r_grant;
    logic [31:0]   r_command;
    logic [GW-1:0] r_gap_cnt;

    logic          w_rr_found;
    logic [1:0]    w_rr_idx;
    logic [1:0]    w_rr_try;
    logic [7:0]    w_data;

    function automatic logic [7:0] key_data(input logic [1:0] k);
        unique case (k)
            2'd0:    key_data = CMD0;
            2'd1:    key_data = CMD1;
            2'd2:    key_data = CMD2;
            default: key_data = CMD3;
        endcase
    endfunction

    // Synchronizer and debounce. The counter only advances while the synchronized sample
    // disagrees with the debounced state; any agreeing sample restarts the stability window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_deb   <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_deb_flip[i]) begin
                    r_deb_cnt[i] <= '0;
                    r_deb[i]     <= r_sync2[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        w_deb_flip = '0;
        w_press    = '0;
        for (int i = 0; i < 4; i++) begin
            w_deb_flip[i] = (r_sync2[i] != r_deb[i]) && (r_deb_cnt[i] == DebLast);
            // Debounced 1->0 only; releases never raise a request.
            w_press[i]    = w_deb_flip[i] & r_deb[i];
        end
    end

    // Round-robin search starting one past the last grant; the last grant itself is tried last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_grant;
        w_rr_try   = '0;
        for (int k = 1; k <= 4; k++) begin
            w_rr_try = r_grant + 2'(k);
            if (!w_rr_found && r_pending[w_rr_try]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_rr_try;
            end
        end
    end

    assign w_data     = key_data(w_rr_idx);
    assign w_grant_oh = 4'b0001 << r_grant;
    assign w_pend_clr = ((r_state == StIssue) && cmd_ready) ? w_grant_oh : 4'b0000;

    // FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        w_state_d = r_state;
        w_rpt_set = '0;
        unique case (r_state)
            StIdle: begin
                if (w_rr_found) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    w_state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    w_state_d = StGap;
                end
            end
            StGap: begin
                if (r_gap_cnt == GapLast) begin
`ifdef IR_REPEAT_EN
                    w_state_d = StHold;
`else
                    w_state_d = StIdle;
`endif
                end
            end
`ifdef IR_REPEAT_EN
            StHold: begin
                if (r_deb[r_grant] || |(r_pending & ~w_grant_oh)) begin
                    w_state_d = StIdle;
                end else if (r_gap_cnt == RptLast) begin
                    w_rpt_set = w_grant_oh;
                    w_state_d = StIdle;
                end
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        cmd_valid = (r_state == StIssue);
        busy      = (r_state != StIdle);
        command   = r_command;
        grant_id  = r_grant;
    end

    // Datapath: pending set, grant/command capture and the shared gap/repeat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_grant   <= 2'd3;
            r_command <= '0;
            r_gap_cnt <= '0;
        end else begin
            // New presses win over the acceptance clear so a re-press is never lost.
            r_pending <= (r_pending & ~w_pend_clr) | w_press | w_rpt_set;
            if ((r_state == StIdle) && w_rr_found) begin
                r_grant   <= w_rr_idx;
                r_command <= {ADDR, ADDR, w_data, ~w_data};
            end
            if (w_state_d != r_state) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != {GW{1'b1}}) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end
        end
    end

endmodule

// File: doc/ir_cmd_scheduler.md
IR_CMD_SCHEDULER -- requirements
Module: ir_cmd_scheduler

Interface
REQ-001 Parameter DEB_CYCLES, 500000, cycles a key input must be stable before its debounced state changes (10 ms at 50 MHz).
REQ-002 Parameter GAP_CYCLES, 5000000, minimum idle cycles between end of one frame and next cmd_valid (100 ms).
REQ-003 Parameter RPT_CYCLES, 5000000, hold time after gap before a held key re-issues (IR_REPEAT_EN only).
REQ-004 Parameter ADDR, 8'h07, Samsung custom code byte.
REQ-005 Parameter CMD0..CMD3, 8'h02/8'h07/8'h0B/8'h0F, data byte for KEY[0]..KEY[3].
REQ-006 clk  input  1  system clock, 50 MHz; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 KEY  input  4  raw push-buttons, active-low, asynchronous to clk.
REQ-009 cmd_ready  input  1  protocol engine can accept a command this cycle.
REQ-010 tx_done  input  1  one-cycle pulse: protocol engine finished the frame.
REQ-011 command  output  32  frame word {ADDR, ADDR, data, ~data}, MSB first.
REQ-012 cmd_valid  output  1  command valid, held until accepted.
REQ-013 grant_id  output  2  index of key owning current/last command.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Each KEY bit SHALL pass a 2-flop synchronizer, then a per-key debounce counter; debounced state changes only after DEB_CYCLES consecutive equal synchronized samples.
REQ-016 A debounced 1->0 transition SHALL set pending[i]; a further press while pending[i]=1 SHALL merge (no count, no overflow).
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, GAP, and HOLD (HOLD only with IR_REPEAT_EN).
REQ-018 IDLE: if any pending bit set, grant round-robin starting at (last grant_id+1) mod 4, load command, go ISSUE next cycle.
REQ-019 ISSUE: cmd_valid=1, command and grant_id stable; on cmd_valid&cmd_ready, clear pending[grant_id] same edge, go WAIT_DONE.
REQ-020 Presses arriving in any state SHALL be recorded; a press on the granted key during WAIT_DONE/GAP sets pending again.
REQ-021 WAIT_DONE: cmd_valid=0; on tx_done go GAP; tx_done outside WAIT_DONE SHALL be ignored.
REQ-022 GAP: count GAP_CYCLES cycles, then go HOLD (IR_REPEAT_EN) or IDLE.
REQ-023 Gap counter SHALL be width ceil(log2(max(GAP_CYCLES,RPT_CYCLES)+1)), saturating, cleared on every state entry.
REQ-024 First cmd_valid after reset SHALL be no earlier than 2 cycles after reset release; round-robin pointer starts so KEY[0] wins a tie.
REQ-025 Simultaneous debounced presses of several keys SHALL be served in round-robin order, one frame each, each separated by GAP.

Reset
REQ-026 On reset: state=IDLE, command=0, cmd_valid=0, grant_id=3, busy=0, pending=0, counters=0, synchronizers and debounced states=1 (released).
REQ-027 Reset asserted mid-frame SHALL drop cmd_valid immediately and discard all pending requests.

Configuration
REQ-028 Macro IR_REPEAT_EN defined: HOLD counts RPT_CYCLES; if grant key still debounced-low at expiry, set its pending and go IDLE; key release or any other pending bit exits HOLD to IDLE at once.
REQ-029 IR_REPEAT_EN undefined: HOLD state and RPT_CYCLES logic absent; one frame per press; GAP exits to IDLE.

Verification (bench params DEB=4, GAP=10, RPT=20, cmd_ready tied 1, tx_done 50 cycles after acceptance)
REQ-030 Pulse KEY[3] low 2 cycles -> no cmd_valid ever (bounce rejected).
REQ-031 Hold KEY[3] low 10 cycles -> one cmd_valid, command=32'h0707_0FF0, grant_id=3.
REQ-032 KEY[0] and KEY[2] pressed same cycle -> commands 32'h0707_02FD then 32'h0707_0BF4, second cmd_valid >=10 cycles after first tx_done.
REQ-033 cmd_ready held 0 for 30 cycles -> cmd_valid and command stable all 30 cycles; accepted on first cycle cmd_ready=1.
REQ-034 Reset pulse during WAIT_DONE with KEY[1] pending -> outputs at reset values, no further cmd_valid.
REQ-035 IR_REPEAT_EN, KEY[1] held 300 cycles -> 32'h0707_07F8 re-issued every frame+GAP+RPT cycles; stops after release; undefined -> single frame.
